dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single memory_system data port between the CPU core (cpu_*) and a host loader/debug master (host_*).
//  Sits between cpu_top/AXI control logic and memory_system, in the cpu_clk domain.
//  Fixed CPU priority with host anti-starvation, one outstanding transaction, per-transaction timeout.
// PARAMETERS
//  ADDR_WIDTH    32   address width, all ports
//  DATA_WIDTH    32   data width, all ports
//  STARVE_LIMIT  4    host wait cycles (>=1) before host wins a tie
//  TIMEOUT       255  max cycles waiting for mem_ready before abort (>=1)
// PORTS
//  clk              in   1   clock (cpu_clk)
//  rst_n            in   1   async active-low reset
//  cpu_addr/host_addr              in   ADDR_WIDTH  request address
//  cpu_write_data/host_write_data  in   DATA_WIDTH  write data
//  cpu_read/host_read              in   1           read request, held until *_ready
//  cpu_write/host_write            in   1           write request, held until *_ready
//  cpu_byte_enable/host_byte_enable in  4           byte lanes
//  cpu_read_data/host_read_data    out  DATA_WIDTH  registered read data
//  cpu_ready/host_ready            out  1           1-cycle completion pulse
//  mem_addr, mem_write_data        out  ADDR/DATA   to memory_system dmem port
//  mem_read, mem_write             out  1           held until mem_ready
//  mem_byte_enable                 out  4
//  mem_read_data                   in   DATA_WIDTH
//  mem_ready                       in   1
//  grant_host       out  1   1 while host owns the port (GRANT_HOST/RESP)
//  timeout_err      out  1   sticky; set on abort
//  err_clear        in   1   clears timeout_err (set wins if same cycle)
//  cpu_grant_cnt, host_grant_cnt   out  32  grant counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all outputs 0; starve_cnt=0; timeout_err=0.
//  FSM: IDLE, GRANT_CPU, GRANT_HOST, RESP.
//   IDLE: req_x = x_read|x_write. Only one requesting -> grant it. Both -> CPU,
//     unless starve_cnt>=STARVE_LIMIT -> host. On grant register addr/wdata/be/op into mem_* regs.
//   GRANT_*: mem_read/mem_write driven from captured op (write wins if both set; read dropped).
//     mem_ready=1 -> capture mem_read_data into owner *_read_data (reads only; writes leave it), go RESP.
//     tmo_cnt reaches TIMEOUT without mem_ready -> deassert mem_*, owner read_data=32'hDEADBEEF,
//     timeout_err<=1, go RESP.
//   RESP: owner *_ready=1 for exactly this cycle; mem_read/mem_write=0; next IDLE.
//  Latency: req in IDLE cycle N -> mem_* valid N+1; mem_ready at cycle M -> *_ready at M+1.
//  Min turnaround 3 cycles with zero-wait memory; requester must drop req the cycle after *_ready.
//  Inputs sampled only in IDLE; changes to a held request mid-transaction are ignored.
//  starve_cnt: +1 each cycle host requests and is not owner (saturates at STARVE_LIMIT); 0 on host grant.
//  tmo_cnt: 0 on grant, +1 per GRANT_* cycle.
//  Non-owner *_ready stays 0 throughout.
//  Reset mid-transaction: transaction dropped, no ready pulse, mem_* deassert asynchronously.
// CONFIGURATION
//  DMEM_ARB_PERF_CNT_EN defined: cpu_grant_cnt/host_grant_cnt +1 on each grant, wrap 2^32-1->0,
//   reset 0. Undefined: both ports tied 32'h0, no counter flops.
// TESTING
//  CPU read 0x100 alone, mem_ready 2 cycles after mem_read, data 0xCAFEF00D -> cpu_ready pulse, cpu_read_data=0xCAFEF00D.
//  CPU write + host read same IDLE cycle -> CPU write completes first, then host read; grant_host 0 then 1.
//  CPU requests back-to-back, host waits, STARVE_LIMIT=4 -> host granted by 2nd IDLE arbitration; starve_cnt back to 0.
//  mem_ready held 0, TIMEOUT=8 -> abort 8 cycles after grant, host_read_data=0xDEADBEEF, timeout_err=1; err_clear -> 0.
//  rst_n low mid-GRANT_CPU -> mem_read=0 immediately, no cpu_ready, state IDLE after release.
//  With DMEM_ARB_PERF_CNT_EN: 3 CPU + 2 host transactions -> cpu_grant_cnt=3, host_grant_cnt=2; without: both 0.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Request/response bundle for one dmem port: CPU, host or memory side.
// master drives the request (addr/write_data/read/write/byte_enable);
// slave returns read_data and the ready handshake.
interface dmem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read;
    logic                  write;
    logic [3:0]            byte_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  ready;

    modport master (
        output addr, write_data, read, write, byte_enable,
        input  read_data, ready
    );

    modport slave (
        input  addr, write_data, read, write, byte_enable,
        output read_data, ready
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the memory_system dmem port between the CPU and a host loader/debug
// master: fixed CPU priority, host anti-starvation, one outstanding
// transaction, per-transaction timeout. Optional grant counters under
// macro DMEM_ARB_PERF_CNT_EN (undefined: counter ports tied to zero).
// Ports: clk, rst_n (async active-low); cpu/host (slave side of the
// request bundle); mem (master side toward memory_system); grant_host;
// timeout_err (sticky) with err_clear; cpu_grant_cnt/host_grant_cnt.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_port_arbiter_if.slave  cpu,
    dmem_port_arbiter_if.slave  host,
    dmem_port_arbiter_if.master mem,
    output logic                grant_host,
    output logic                timeout_err,
    input  logic                err_clear,
    output logic [31:0]         cpu_grant_cnt,
    output logic [31:0]         host_grant_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] ABORT_DATA =
        DATA_WIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT_CPU,
        S_GRANT_HOST,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_be;
    logic                  r_op_read;
    logic                  r_op_write;
    logic                  r_owner_host;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic [SW-1:0]         r_starve;
    logic [TW-1:0]         r_tmo;
    logic                  r_err;

    logic w_cpu_req;
    logic w_host_req;
    logic w_starved;
    logic w_in_grant;
    logic w_grant_cpu;
    logic w_grant_host;
    logic w_mem_done;
    logic w_abort;

    assign w_cpu_req  = cpu.read | cpu.write;
    assign w_host_req = host.read | host.write;
    assign w_starved  = (r_starve >= STARVE_MAX);
    assign w_in_grant = (r_state == S_GRANT_CPU) ||
                        (r_state == S_GRANT_HOST);

    always_comb begin
        w_next_state = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_host = 1'b0;
        w_mem_done   = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Host wins a tie only once it has waited long enough.
                if (w_host_req && (!w_cpu_req || w_starved)) begin
                    w_grant_host = 1'b1;
                    w_next_state = S_GRANT_HOST;
                end else if (w_cpu_req) begin
                    w_grant_cpu  = 1'b1;
                    w_next_state = S_GRANT_CPU;
                end
            end
            S_GRANT_CPU, S_GRANT_HOST: begin
                // A ready arriving in the last allowed cycle still counts.
                if (mem.ready) begin
                    w_mem_done   = 1'b1;
                    w_next_state = S_RESP;
                end else if (r_tmo == TMO_LAST) begin
                    w_abort      = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_op_read    <= 1'b0;
            r_op_write   <= 1'b0;
            r_owner_host <= 1'b0;
            r_tmo        <= '0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            if (w_grant_cpu) begin
                r_mem_addr   <= cpu.addr;
                r_mem_wdata  <= cpu.write_data;
                r_mem_be     <= cpu.byte_enable;
                r_op_read    <= cpu.read;
                r_op_write   <= cpu.write;
                r_owner_host <= 1'b0;
            end else if (w_grant_host) begin
                r_mem_addr   <= host.addr;
                r_mem_wdata  <= host.write_data;
                r_mem_be     <= host.byte_enable;
                r_op_read    <= host.read;
                r_op_write   <= host.write;
                r_owner_host <= 1'b1;
            end

            if (w_grant_cpu || w_grant_host) begin
                r_tmo <= '0;
            end else if (w_in_grant) begin
                r_tmo <= r_tmo + TW'(1);
            end

            // Writes (including read+write, where write wins) keep old data.
            if (w_mem_done && r_op_read && !r_op_write) begin
                if (r_owner_host) begin
                    r_host_rdata <= mem.read_data;
                end else begin
                    r_cpu_rdata <= mem.read_data;
                end
            end else if (w_abort) begin
                if (r_owner_host) begin
                    r_host_rdata <= ABORT_DATA;
                end else begin
                    r_cpu_rdata <= ABORT_DATA;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_grant_host) begin
            r_starve <= '0;
        end else if (w_host_req && !grant_host && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end else if (err_clear) begin
            r_err <= 1'b0;
        end
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] r_cpu_gcnt;
    logic [31:0] r_host_gcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_gcnt  <= '0;
            r_host_gcnt <= '0;
        end else begin
            if (w_grant_cpu) begin
                r_cpu_gcnt <= r_cpu_gcnt + 32'd1;
            end
            if (w_grant_host) begin
                r_host_gcnt <= r_host_gcnt + 32'd1;
            end
        end
    end

    assign cpu_grant_cnt  = r_cpu_gcnt;
    assign host_grant_cnt = r_host_gcnt;
`else
    assign cpu_grant_cnt  = 32'h0;
    assign host_grant_cnt = 32'h0;
`endif

    // Strobes derive from state so reset drops them without a clock.
    assign mem.addr        = r_mem_addr;
    assign mem.write_data  = r_mem_wdata;
    assign mem.byte_enable = r_mem_be;
    assign mem.read        = w_in_grant && r_op_read && !r_op_write;
    assign mem.write       = w_in_grant && r_op_write;

    assign cpu.read_data  = r_cpu_rdata;
    assign host.read_data = r_host_rdata;
    assign cpu.ready      = (r_state == S_RESP) && !r_owner_host;
    assign host.ready     = (r_state == S_RESP) && r_owner_host;

    assign grant_host  = (r_state == S_GRANT_HOST) ||
                         ((r_state == S_RESP) && r_owner_host);
    assign timeout_err = r_err;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: random and directed traffic from
// CPU and host, a behavioural memory, and a ready-driven checker.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        err_clear = 1'b0;
    logic        grant_host;
    logic        timeout_err;
    logic [31:0] cpu_grant_cnt;
    logic [31:0] host_grant_cnt;

    dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();
    dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) host_if ();
    dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    dmem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .STARVE_LIMIT(SL), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu(cpu_if),
        .host(host_if),
        .mem(mem_if),
        .grant_host(grant_host),
        .timeout_err(timeout_err),
        .err_clear(err_clear),
        .cpu_grant_cnt(cpu_grant_cnt),
        .host_grant_cnt(host_grant_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];
    logic [31:0] cpu_q[$];
    logic [31:0] host_q[$];
    logic [31:0] last_rd[2];
    int          exp_gr[2];
    bit          done_log[$];
    bit          mem_stall = 1'b0;
    int          fixed_lat = -1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural memory: answers after 0..3 wait cycles unless stalled.
    initial begin
        int pend;
        pend = -1;
        mem_if.ready = 1'b0;
        mem_if.read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_if.ready = 1'b0;
            if (!(mem_if.read || mem_if.write) || mem_stall) begin
                pend = -1;
            end else begin
                if (pend < 0)
                    pend = (fixed_lat >= 0) ? fixed_lat
                                            : int'($urandom_range(0, 3));
                if (pend == 0) begin
                    if (mem_if.write)
                        smem[mem_if.addr] = merge(smem_rd(mem_if.addr),
                                                  mem_if.write_data,
                                                  mem_if.byte_enable);
                    else
                        mem_if.read_data = smem_rd(mem_if.addr);
                    mem_if.ready = 1'b1;
                    pend = -1;
                end else begin
                    pend--;
                end
            end
        end
    end

    // Checker: pops the expected response whenever a ready pulse shows.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_if.ready) begin
                check("cpu_excl_ready", {31'd0, host_if.ready}, 32'd0);
                check("cpu_grant_host", {31'd0, grant_host}, 32'd0);
                if (cpu_q.size() == 0)
                    check("cpu_unexp_ready", {31'd0, cpu_if.ready}, 32'd0);
                else
                    check("cpu_rdata", cpu_if.read_data, cpu_q.pop_front());
                done_log.push_back(1'b0);
            end
            if (host_if.ready) begin
                check("host_grant_host", {31'd0, grant_host}, 32'd1);
                if (host_q.size() == 0)
                    check("host_unexp_ready", {31'd0, host_if.ready}, 32'd0);
                else
                    check("host_rdata", host_if.read_data, host_q.pop_front());
                done_log.push_back(1'b1);
            end
        end
    end

    // Issue one transaction; call at posedge+1. Returns cycles to ready.
    task automatic txn(input bit h, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be,
                       input bit tmo, output int cyc);
        logic [31:0] e;
        bit rdy;
        exp_gr[h]++;
        if (tmo) begin
            e = 32'hDEADBEEF;
            last_rd[h] = e;
        end else if (wr) begin
            ref_mem[addr] = merge(ref_rd(addr), data, be);
            e = last_rd[h];
        end else begin
            e = ref_rd(addr);
            last_rd[h] = e;
        end
        if (h) begin
            host_q.push_back(e);
            host_if.addr = addr;
            host_if.write_data = data;
            host_if.byte_enable = be;
            host_if.read = !wr;
            host_if.write = wr;
        end else begin
            cpu_q.push_back(e);
            cpu_if.addr = addr;
            cpu_if.write_data = data;
            cpu_if.byte_enable = be;
            cpu_if.read = !wr;
            cpu_if.write = wr;
        end
        cyc = 0;
        do begin
            tick(1);
            cyc++;
            rdy = h ? host_if.ready : cpu_if.ready;
        end while (!rdy && cyc < 60);
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL txn_wait: port %0d no ready after %0d cycles",
                     h, cyc);
        end
        if (h) begin
            host_if.read = 1'b0;
            host_if.write = 1'b0;
        end else begin
            cpu_if.read = 1'b0;
            cpu_if.write = 1'b0;
        end
    endtask

    task automatic rand_txn(input bit h);
        int c;
        logic [31:0] a;
        a = {22'd0, 6'($urandom_range(0, 63)), 2'b00};
        if (h) a = a + 32'h1000;
        txn(h, 1'($urandom), a, $urandom, 4'($urandom), 1'b0, c);
    endtask

    task automatic check_log(input string name, input bit e0, input bit e1);
        check({name, "_n"}, done_log.size(), 32'd2);
        if (done_log.size() >= 2) begin
            check({name, "_0"}, {31'd0, done_log[0]}, {31'd0, e0});
            check({name, "_1"}, {31'd0, done_log[1]}, {31'd0, e1});
        end
    endtask

    task automatic check_cnt(input string name);
`ifdef DMEM_ARB_PERF_CNT_EN
        check({name, "_cpu"}, cpu_grant_cnt, exp_gr[0]);
        check({name, "_host"}, host_grant_cnt, exp_gr[1]);
`else
        check({name, "_cpu"}, cpu_grant_cnt, 32'd0);
        check({name, "_host"}, host_grant_cnt, 32'd0);
`endif
    endtask

    initial begin
        int cyc;
        cpu_if.addr = '0;
        cpu_if.write_data = '0;
        cpu_if.byte_enable = '0;
        cpu_if.read = 1'b0;
        cpu_if.write = 1'b0;
        host_if.addr = '0;
        host_if.write_data = '0;
        host_if.byte_enable = '0;
        host_if.read = 1'b0;
        host_if.write = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        exp_gr[0] = 0;
        exp_gr[1] = 0;

        #3 rst_n = 1'b0;
        #10;
        check("rst_mem_read", {31'd0, mem_if.read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_if.write}, 32'd0);
        check("rst_cpu_ready", {31'd0, cpu_if.ready}, 32'd0);
        check("rst_host_ready", {31'd0, host_if.ready}, 32'd0);
        check("rst_grant_host", {31'd0, grant_host}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_cpu_rdata", cpu_if.read_data, 32'd0);
        check("rst_host_rdata", host_if.read_data, 32'd0);
        check("rst_mem_addr", mem_if.addr, 32'd0);
        check_cnt("rst_cnt");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        ref_mem[32'h100] = 32'hCAFEF00D;
        smem[32'h100] = 32'hCAFEF00D;
        fixed_lat = 2;
        txn(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, cyc);
        check("t1_latency", cyc, 32'd4);
        check("t1_cpu_rdata", cpu_if.read_data, 32'hCAFEF00D);

        // CPU runs back-to-back; host must cut in at the 2nd arbitration.
        fixed_lat = 1;
        tick(2);
        done_log.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) rand_txn(1'b0);
            end
            begin
                rand_txn(1'b1);
            end
        join
        tick(2);
        check("starve_n", done_log.size(), 32'd4);
        if (done_log.size() >= 2) begin
            check("starve_first", {31'd0, done_log[0]}, 32'd0);
            check("starve_host2", {31'd0, done_log[1]}, 32'd1);
        end

        // Tie from fresh starve count: CPU first, then host.
        fixed_lat = -1;
        tick(2);
        done_log.delete();
        fork
            txn(1'b0, 1'b1, 32'h8, 32'h11223344, 4'b0101, 1'b0, cyc);
            txn(1'b1, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0, cyc);
        join
        tick(2);
        check_log("tie", 1'b0, 1'b1);

        mem_stall = 1'b1;
        txn(1'b1, 1'b0, 32'h1040, 32'h0, 4'hF, 1'b1, cyc);
        mem_stall = 1'b0;
        check("tmo_latency", cyc, 32'd9);
        check("tmo_err_set", {31'd0, timeout_err}, 32'd1);
        tick(2);
        check("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("tmo_err_clear", {31'd0, timeout_err}, 32'd0);

        // Reset while CPU read is waiting on a stalled memory.
        mem_stall = 1'b1;
        cpu_if.addr = 32'h40;
        cpu_if.read = 1'b1;
        tick(2);
        check("mid_mem_read", {31'd0, mem_if.read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mem_read", {31'd0, mem_if.read}, 32'd0);
        check("mid_rst_cpu_ready", {31'd0, cpu_if.ready}, 32'd0);
        cpu_if.read = 1'b0;
        mem_stall = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        exp_gr[0] = 0;
        exp_gr[1] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);
        check("post_rst_grant", {31'd0, grant_host}, 32'd0);
        check("post_rst_mem_read", {31'd0, mem_if.read}, 32'd0);
        fixed_lat = 2;
        txn(1'b0, 1'b0, 32'h44, 32'h0, 4'hF, 1'b0, cyc);
        check("post_rst_latency", cyc, 32'd4);
        txn(1'b0, 1'b1, 32'h48, 32'hA5A5A5A5, 4'hF, 1'b0, cyc);
        txn(1'b0, 1'b0, 32'h48, 32'h0, 4'hF, 1'b0, cyc);
        txn(1'b1, 1'b1, 32'h1048, 32'h5A5A5A5A, 4'h3, 1'b0, cyc);
        txn(1'b1, 1'b0, 32'h1048, 32'h0, 4'hF, 1'b0, cyc);
        tick(2);
        check_cnt("perf_3_2");

        fixed_lat = -1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    tick($urandom_range(0, 3));
                    rand_txn(1'b0);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    tick($urandom_range(0, 3));
                    rand_txn(1'b1);
                end
            end
        join
        tick(3);
        check("drain_cpu_q", cpu_q.size(), 32'd0);
        check("drain_host_q", host_q.size(), 32'd0);
        check_cnt("perf_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
